// File: rtl/divu_seq_pkg.sv
// Shared types and constants for the sequential unsigned divider (DIVU).
package divu_seq_pkg;

    typedef enum logic [1:0] {
        DIVU_IDLE,
        DIVU_CALC,
        DIVU_DONE
    } divu_state_t;

    localparam int DIVU_XLEN    = 32;
    // Cycles from an accepted start to the done pulse; stall logic keys off this.
    localparam int DIVU_LATENCY = DIVU_XLEN + 1;

endpackage

// File: rtl/divu_step.sv
// One restoring radix-2 division iteration, purely combinational.
module divu_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] div,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          unused_rem_msb;

    assign shifted   = {rem[XLEN-1:0], quot[XLEN-1]};
    assign diff      = shifted - {1'b0, div};
    // A set top bit means the trial subtraction borrowed: keep the shifted value.
    assign rem_next  = diff[XLEN] ? shifted : diff;
    assign quot_next = {quot[XLEN-2:0], ~diff[XLEN]};

    // The partial remainder always stays below the divisor, so its top bit is never consumed.
    assign unused_rem_msb = rem[XLEN];

endmodule

// File: rtl/divu_seq.sv
// Multi-cycle restoring unsigned divider executing DIVU beside the single-cycle ALU.
// Optional DIVU_FAST_EN: divisor==0, dividend<divisor and divisor==1 finish in one cycle.
module divu_seq
    import divu_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    divu_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN:0]   rem_reg;
    logic [XLEN-1:0] quot_reg;
    logic [XLEN-1:0] div_reg;
    logic [XLEN-1:0] quotient_reg;
    logic [XLEN-1:0] remainder_reg;

    logic [XLEN:0]   rem_next;
    logic [XLEN-1:0] quot_next;
    logic            accept;
    logic            last_iter;

    divu_step #(.XLEN(XLEN)) u_step (
        .rem       (rem_reg),
        .quot      (quot_reg),
        .div       (div_reg),
        .rem_next  (rem_next),
        .quot_next (quot_next)
    );

    // New work is only taken when the unit is not mid-calculation.
    assign accept    = start_i && !flush_i &&
                       ((state_reg == DIVU_IDLE) || (state_reg == DIVU_DONE));
    assign last_iter = (state_reg == DIVU_CALC) && (cnt_reg == CNT_W'(XLEN - 1));

`ifdef DIVU_FAST_EN
    logic            fast_hit;
    logic [XLEN-1:0] fast_quot;
    logic [XLEN-1:0] fast_rem;

    always_comb begin
        fast_hit  = 1'b0;
        fast_quot = '0;
        fast_rem  = '0;
        if (divisor_i == '0) begin
            fast_hit  = 1'b1;
            fast_quot = '1;
            fast_rem  = dividend_i;
        end else if (dividend_i < divisor_i) begin
            fast_hit  = 1'b1;
            fast_quot = '0;
            fast_rem  = dividend_i;
        end else if (divisor_i == XLEN'(1)) begin
            fast_hit  = 1'b1;
            fast_quot = dividend_i;
            fast_rem  = '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= DIVU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_reg)
            DIVU_IDLE: begin
                if (accept) begin
`ifdef DIVU_FAST_EN
                    state_next = fast_hit ? DIVU_DONE : DIVU_CALC;
`else
                    state_next = DIVU_CALC;
`endif
                end
            end
            DIVU_CALC: begin
                busy_o = 1'b1;
                if (last_iter) begin
                    state_next = DIVU_DONE;
                end
            end
            DIVU_DONE: begin
                done_o = 1'b1;
                if (accept) begin
`ifdef DIVU_FAST_EN
                    state_next = fast_hit ? DIVU_DONE : DIVU_CALC;
`else
                    state_next = DIVU_CALC;
`endif
                end else begin
                    state_next = DIVU_IDLE;
                end
            end
            default: state_next = DIVU_IDLE;
        endcase
        if (flush_i) begin
            state_next = DIVU_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            div_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else if (accept) begin
            cnt_reg  <= '0;
            rem_reg  <= '0;
            quot_reg <= dividend_i;
            div_reg  <= divisor_i;
`ifdef DIVU_FAST_EN
            if (fast_hit) begin
                quotient_reg  <= fast_quot;
                remainder_reg <= fast_rem;
            end
`endif
        end else if ((state_reg == DIVU_CALC) && !flush_i) begin
            rem_reg  <= rem_next;
            quot_reg <= quot_next;
            // Holding at XLEN-1 keeps the counter from wrapping on power-of-two widths.
            if (last_iter) begin
                quotient_reg  <= quot_next;
                remainder_reg <= rem_next[XLEN-1:0];
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign quotient_o  = quotient_reg;
    assign remainder_o = remainder_reg;

endmodule

// File: tb/tb_divu_seq.sv
// Self-checking bench for divu_seq; honours DIVU_FAST_EN when the build defines it.
`timescale 1ns/1ps
module tb_divu_seq;

    localparam int XLEN    = 32;
    localparam int LATENCY = XLEN + 1;

    logic            clk;
    logic            rst_n;
    logic            start_i;
    logic            flush_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] quotient_o;
    logic [XLEN-1:0] remainder_o;

    int vectors    = 0;
    int miscompares = 0;
    logic [XLEN-1:0] last_q = '0;
    logic [XLEN-1:0] last_r = '0;

    divu_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .flush_i     (flush_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain arithmetic with the RISC-V divide-by-zero rule.
    function automatic void ref_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                    output logic [XLEN-1:0] q, output logic [XLEN-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef DIVU_FAST_EN
        if (b == '0 || a < b || b == 1) return 1;
`endif
        return LATENCY;
    endfunction

    task automatic kick(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
    endtask

    // lat counts cycles since the accept edge (1 = first cycle after it).
    task automatic wait_done(input int lat0, output int lat, output int busy, output bit to);
        lat  = lat0;
        busy = 0;
        while (!done_o && lat < 200) begin
            if (busy_o) busy++;
            @(posedge clk); #1;
            lat++;
        end
        to = !done_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; dividend_i = '0; divisor_i = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy_o, done_o, quotient_o, remainder_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h, want all zero",
                     busy_o, done_o, quotient_o, remainder_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy_o, done_o);
        end
        $display("reset: released");
    endtask

    task automatic run_list(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] eq, er;
        int lat, busy;
        bit to;
        ref_div(a, b, eq, er);
        kick(a, b);
        wait_done(1, lat, busy, to);
        $display("%s: %h / %h -> q=%h r=%h lat=%0d busy=%0d", tag, a, b, quotient_o, remainder_o, lat, busy);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL %s_timeout: no done_o within 200 cycles", tag);
        end
        vectors++;
        if (quotient_o !== eq || remainder_o !== er) begin
            miscompares++;
            $display("FAIL %s_result: got q=%h r=%h, want q=%h r=%h", tag, quotient_o, remainder_o, eq, er);
        end
        vectors++;
        if (lat != exp_lat(a, b) || busy != exp_lat(a, b) - 1) begin
            miscompares++;
            $display("FAIL %s_latency: got lat=%0d busy=%0d, want lat=%0d busy=%0d",
                     tag, lat, busy, exp_lat(a, b), exp_lat(a, b) - 1);
        end
        last_q = eq;
        last_r = er;
        @(posedge clk); #1;
        vectors++;
        if (done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_pulse: got done=%b one cycle later, want 0", tag, done_o);
        end
    endtask

    task automatic test_edge_cases();
        logic [XLEN-1:0] as [6] = '{32'd100, 32'h12345678, 32'hFFFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF};
        logic [XLEN-1:0] bs [6] = '{32'd7,   32'd0,        32'd1,        32'd9, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) run_list("edge", as[i], bs[i]);
    endtask

    task automatic test_random();
        logic [XLEN-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 16);
                2: b = a >> $urandom_range(0, 31);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_list("rand", a, b);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy;
        bit to;
        kick(32'd1000, 32'd10);
        repeat (4) begin @(posedge clk); #1; end
        dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(6, lat, busy, to);
        $display("ignore: 1000/10 with stray 9/3 -> q=%0d r=%0d lat=%0d", quotient_o, remainder_o, lat);
        vectors++;
        if (to || quotient_o !== 32'd100 || remainder_o !== 32'd0 || lat != LATENCY) begin
            miscompares++;
            $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d to=%b, want q=100 r=0 lat=%0d",
                     quotient_o, remainder_o, lat, to, LATENCY);
        end
        // Start presented during the DONE cycle must be accepted immediately.
        kick(32'd20, 32'd3);
        wait_done(1, lat, busy, to);
        $display("b2b: 20/3 -> q=%0d r=%0d lat=%0d", quotient_o, remainder_o, lat);
        vectors++;
        if (to || quotient_o !== 32'd6 || remainder_o !== 32'd2 || lat != LATENCY) begin
            miscompares++;
            $display("FAIL back_to_back: got q=%0d r=%0d lat=%0d to=%b, want q=6 r=2 lat=%0d",
                     quotient_o, remainder_o, lat, to, LATENCY);
        end
        last_q = 32'd6;
        last_r = 32'd2;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int seen;
        kick(32'd1000, 32'd10);
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: got busy=%b done=%b, want 0 0", busy_o, done_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen != 0 || quotient_o !== last_q || remainder_o !== last_r) begin
            miscompares++;
            $display("FAIL flush_outputs: got dones=%0d q=%h r=%h, want dones=0 q=%h r=%h",
                     seen, quotient_o, remainder_o, last_q, last_r);
        end
        $display("flush: mid-op abort, dones=%0d", seen);
        dividend_i = 32'd9; divisor_i = 32'd0; start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o || busy_o) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen != 0 || quotient_o !== last_q || remainder_o !== last_r) begin
            miscompares++;
            $display("FAIL flush_start: got active=%0d q=%h r=%h, want active=0 q=%h r=%h",
                     seen, quotient_o, remainder_o, last_q, last_r);
        end
        $display("flush: flush+start in idle, active cycles=%0d", seen);
    endtask

    task automatic test_async_reset();
        int seen, lat, busy;
        bit to;
        kick(32'd77, 32'd5);
        repeat (11) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy_o, done_o, quotient_o, remainder_o} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b q=%h r=%h, want all zero",
                     busy_o, done_o, quotient_o, remainder_o);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", seen);
        end
        kick(32'd77, 32'd5);
        wait_done(1, lat, busy, to);
        $display("reset: 77/5 after reset -> q=%0d r=%0d lat=%0d", quotient_o, remainder_o, lat);
        vectors++;
        if (to || quotient_o !== 32'd15 || remainder_o !== 32'd2 || lat != LATENCY) begin
            miscompares++;
            $display("FAIL reset_rerun: got q=%0d r=%0d lat=%0d to=%b, want q=15 r=2 lat=%0d",
                     quotient_o, remainder_o, lat, to, LATENCY);
        end
    endtask

    initial begin
        test_reset();
        test_edge_cases();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
